sram_write_cmd_gen: RTL and testbench

- Command generator stage directly upstream of the SRAM write collector in the DMA pipeline.
- Takes one fill request: a contiguous DRAM word range plus front and back padding counts.
- Emits the per-cache-line DRAM read addresses and the collector command stream: type 2 pad commands, then type 0 linear commands split at cache-line and vector boundaries, then trailing pad commands.
- Generates `islast` so the collector releases each DRAM line exactly once.

---
 rtl/sram_write_cmd_gen.sv | 203 ++++++++++++++++++++
 tb/tb_sram_write_cmd_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sram_write_cmd_gen.sv
// ============================================================================
// sram_write_cmd_gen : turns one fill request into DRAM line reads and
// pad / linear commands for the SRAM write collector.   Rev 1.0
// ============================================================================
`default_nettype none

module sram_write_cmd_gen #(
  parameter int GBW   = 32,
  parameter int LBW   = 15,
  parameter int CSIZE = 32,
  parameter int VSIZE = 32,
  localparam int CC_BW  = $clog2(CSIZE),
  localparam int CV_BW1 = $clog2(VSIZE + 1),
  localparam int LW     = LBW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_rdy,
  output logic              o_req_ack,
  input  logic              i_which,
  input  logic [GBW-1:0]    i_addr,
  input  logic [LW-1:0]     i_len,
  input  logic [LW-1:0]     i_padf,
  input  logic [LW-1:0]     i_padb,
  output logic              o_dramra_rdy,
  input  logic              i_dramra_ack,
  output logic [GBW-CC_BW-1:0] o_dramra,
  output logic              o_cmd_rdy,
  input  logic              i_cmd_ack,
  output logic              o_which,
  output logic [1:0]        o_cmd_type,
  output logic              o_cmd_islast,
  output logic [CC_BW-1:0]  o_cmd_addrofs,
  output logic [CV_BW1-1:0] o_cmd_len
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PADF = 2'd1,
    S_LINE = 2'd2,
    S_PADB = 2'd3
  } state_t;

  localparam logic [LW-1:0]    c_VSIZE = LW'(VSIZE);
  localparam logic [CC_BW:0]   c_CSIZE = (CC_BW + 1)'(CSIZE);

  state_t              r_state, w_nxt;
  logic                r_which;
  logic [GBW-1:0]      r_cur;
  logic [LW-1:0]       r_padf, r_len, r_padb;
  logic                r_first;

  logic                r_cmd_rdy, r_cmd_last, r_cmd_which, r_dramra_rdy;
  logic [1:0]          r_cmd_type;
  logic [CC_BW-1:0]    r_cmd_ofs;
  logic [CV_BW1-1:0]   r_cmd_len;
  logic [GBW-CC_BW-1:0] r_dramra;

  logic [CC_BW-1:0]    w_ofs;
  logic [CC_BW:0]      w_room;
  logic [LW-1:0]       w_rem, w_vmin, w_lmin;
  logic                w_line_last, w_new_line, w_slot, w_dslot;
  logic                w_load, w_ld_last, w_ld_dram;
  logic [1:0]          w_ld_type;
  logic [LW-1:0]       w_ld_len;
  logic [CC_BW-1:0]    w_ld_ofs;

  assign w_ofs   = r_cur[CC_BW-1:0];
  assign w_room  = c_CSIZE - {1'b0, w_ofs};
  assign w_slot  = !r_cmd_rdy || i_cmd_ack;
  assign w_dslot = !r_dramra_rdy || i_dramra_ack;

  always_comb begin
    w_rem = r_padb;
    case (r_state)
      S_PADF:  w_rem = r_padf;
      S_LINE:  w_rem = r_len;
      default: w_rem = r_padb;
    endcase
  end

  assign w_vmin      = (w_rem < c_VSIZE) ? w_rem : c_VSIZE;
  assign w_lmin      = (w_vmin < LW'(w_room)) ? w_vmin : LW'(w_room);
  assign w_line_last = (({1'b0, w_ofs} + w_lmin[CC_BW:0]) == c_CSIZE) || (w_lmin == w_rem);
  // A line fetch goes out with the first linear command and at every line start.
  assign w_new_line  = r_first || (w_ofs == '0);

  always_comb begin
    w_nxt     = r_state;
    o_req_ack = 1'b0;
    w_load    = 1'b0;
    w_ld_type = 2'd2;
    w_ld_len  = w_vmin;
    w_ld_ofs  = '0;
    w_ld_last = 1'b0;
    w_ld_dram = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ack = i_req_rdy;
        if (i_req_rdy) begin
          if (i_padf != '0)      w_nxt = S_PADF;
          else if (i_len != '0)  w_nxt = S_LINE;
          else if (i_padb != '0) w_nxt = S_PADB;
        end
      end
      S_PADF: begin
        if (w_slot) begin
          w_load = 1'b1;
          if (w_vmin == w_rem) begin
            if (r_len != '0)       w_nxt = S_LINE;
            else if (r_padb != '0) w_nxt = S_PADB;
            else                   w_nxt = S_IDLE;
          end
        end
      end
      S_LINE: begin
        if (w_slot && (!w_new_line || w_dslot)) begin
          w_load    = 1'b1;
          w_ld_type = 2'd0;
          w_ld_len  = w_lmin;
          w_ld_ofs  = w_ofs;
          w_ld_last = w_line_last;
          w_ld_dram = w_new_line;
          if (w_lmin == w_rem) w_nxt = (r_padb != '0) ? S_PADB : S_IDLE;
        end
      end
      default: begin
        if (w_slot) begin
          w_load = 1'b1;
          if (w_vmin == w_rem) w_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_which      <= 1'b0;
      r_cur        <= '0;
      r_padf       <= '0;
      r_len        <= '0;
      r_padb       <= '0;
      r_first      <= 1'b0;
      r_cmd_rdy    <= 1'b0;
      r_cmd_type   <= 2'd0;
      r_cmd_ofs    <= '0;
      r_cmd_len    <= '0;
      r_cmd_last   <= 1'b0;
      r_cmd_which  <= 1'b0;
      r_dramra_rdy <= 1'b0;
      r_dramra     <= '0;
    end else begin
      if (r_cmd_rdy && i_cmd_ack)       r_cmd_rdy    <= 1'b0;
      if (r_dramra_rdy && i_dramra_ack) r_dramra_rdy <= 1'b0;
      if (r_state == S_IDLE && i_req_rdy) begin
        r_which <= i_which;
        r_cur   <= i_addr;
        r_padf  <= i_padf;
        r_len   <= i_len;
        r_padb  <= i_padb;
        r_first <= 1'b1;
      end
      if (w_load) begin
        r_cmd_rdy   <= 1'b1;
        r_cmd_type  <= w_ld_type;
        r_cmd_ofs   <= w_ld_ofs;
        r_cmd_len   <= w_ld_len[CV_BW1-1:0];
        r_cmd_last  <= w_ld_last;
        r_cmd_which <= r_which;
        case (r_state)
          S_PADF: r_padf <= r_padf - w_ld_len;
          S_LINE: begin
            r_len   <= r_len - w_ld_len;
            r_cur   <= r_cur + GBW'(w_ld_len);
            r_first <= 1'b0;
          end
          default: r_padb <= r_padb - w_ld_len;
        endcase
      end
      if (w_load && w_ld_dram) begin
        r_dramra_rdy <= 1'b1;
        r_dramra     <= r_cur[GBW-1:CC_BW];
      end
    end
  end

  assign o_cmd_rdy     = r_cmd_rdy;
  assign o_cmd_type    = r_cmd_type;
  assign o_cmd_addrofs = r_cmd_ofs;
  assign o_cmd_len     = r_cmd_len;
  assign o_cmd_islast  = r_cmd_last;
  assign o_which       = r_cmd_which;
  assign o_dramra_rdy  = r_dramra_rdy;
  assign o_dramra      = r_dramra;

endmodule

`default_nettype wire

// File: tb/tb_sram_write_cmd_gen.sv
// ============================================================================
// tb_sram_write_cmd_gen : directed vector bench for sram_write_cmd_gen
// (CSIZE=8, VSIZE=4, GBW=16).   Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_write_cmd_gen;

  localparam int GBW = 16, LBW = 15, CSIZE = 8, VSIZE = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_rdy = 1'b0, req_ack, which = 1'b0;
  logic [15:0] addr = '0, len = '0, padf = '0, padb = '0;
  logic        dramra_rdy, dramra_ack = 1'b1;
  logic [12:0] dramra;
  logic        cmd_rdy, cmd_ack = 1'b1, o_wh, cmd_last;
  logic [1:0]  cmd_type;
  logic [2:0]  cmd_ofs, cmd_len;

  sram_write_cmd_gen #(.GBW(GBW), .LBW(LBW), .CSIZE(CSIZE), .VSIZE(VSIZE)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_rdy(req_rdy), .o_req_ack(req_ack),
    .i_which(which), .i_addr(addr), .i_len(len), .i_padf(padf), .i_padb(padb),
    .o_dramra_rdy(dramra_rdy), .i_dramra_ack(dramra_ack), .o_dramra(dramra),
    .o_cmd_rdy(cmd_rdy), .i_cmd_ack(cmd_ack), .o_which(o_wh),
    .o_cmd_type(cmd_type), .o_cmd_islast(cmd_last), .o_cmd_addrofs(cmd_ofs),
    .o_cmd_len(cmd_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr, len, padf, padb;
    logic        wh;
    int          ncmd, cidx, ndram, d0, d1;
  } req_t;
  typedef struct { int typ, ofs, len, last; } cmd_t;
  typedef struct { int typ, ofs, len, last, wh, cyc; } obs_t;

  req_t reqs[5];
  cmd_t exp_c[16];
  obs_t cq[$];
  int   dq[$];
  int   cyc = 0, n_chk = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are observed mid-cycle, where rdy/ack are stable until the next edge.
  always @(negedge clk) begin
    if (rst) begin
      if (cmd_rdy && cmd_ack)
        cq.push_back('{int'(cmd_type), int'(cmd_ofs), int'(cmd_len), int'(cmd_last), int'(o_wh), cyc});
      if (dramra_rdy && dramra_ack) dq.push_back(int'(dramra));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic do_req(input logic [15:0] a, l, pf, pb, input logic w);
    @(posedge clk); #1;
    req_rdy = 1'b1; addr = a; len = l; padf = pf; padb = pb; which = w;
    @(negedge clk);
    chk("req_ack", int'(req_ack), 1);
    @(posedge clk); #1;
    req_rdy = 1'b0;
  endtask

  task automatic wait_cmds(input int n);
    for (int t = 0; t < 100 && cq.size() < n; t++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_req(input int k);
    req_t r;
    r = reqs[k];
    cq.delete(); dq.delete();
    do_req(r.addr, r.len, r.padf, r.padb, r.wh);
    wait_cmds(r.ncmd);
    chk($sformatf("r%0d ncmd", k), cq.size(), r.ncmd);
    for (int i = 0; i < r.ncmd && i < cq.size(); i++) begin
      chk($sformatf("r%0d c%0d type", k, i), cq[i].typ, exp_c[r.cidx+i].typ);
      chk($sformatf("r%0d c%0d ofs", k, i),  cq[i].ofs, exp_c[r.cidx+i].ofs);
      chk($sformatf("r%0d c%0d len", k, i),  cq[i].len, exp_c[r.cidx+i].len);
      chk($sformatf("r%0d c%0d last", k, i), cq[i].last, exp_c[r.cidx+i].last);
      chk($sformatf("r%0d c%0d which", k, i), cq[i].wh, int'(r.wh));
    end
    chk($sformatf("r%0d ndram", k), dq.size(), r.ndram);
    if (r.ndram > 0 && dq.size() > 0) chk($sformatf("r%0d dram0", k), dq[0], r.d0);
    if (r.ndram > 1 && dq.size() > 1) chk($sformatf("r%0d dram1", k), dq[1], r.d1);
  endtask

  initial begin
    reqs[0] = '{16'd13,     16'd10, 16'd0, 16'd0, 1'b1, 3, 0,  2, 1,     2};
    reqs[1] = '{16'd0,      16'd8,  16'd5, 16'd2, 1'b0, 5, 3,  1, 0,     0};
    reqs[2] = '{16'd6,      16'd4,  16'd0, 16'd0, 1'b1, 2, 8,  2, 0,     1};
    reqs[3] = '{16'd3,      16'd2,  16'd0, 16'd9, 1'b0, 4, 10, 1, 0,     0};
    reqs[4] = '{16'hFFFE,   16'd4,  16'd0, 16'd0, 1'b1, 2, 14, 2, 'h1FFF, 0};
    exp_c[0]  = '{0, 5, 3, 1}; exp_c[1]  = '{0, 0, 4, 0}; exp_c[2]  = '{0, 4, 3, 1};
    exp_c[3]  = '{2, 0, 4, 0}; exp_c[4]  = '{2, 0, 1, 0}; exp_c[5]  = '{0, 0, 4, 0};
    exp_c[6]  = '{0, 4, 4, 1}; exp_c[7]  = '{2, 0, 2, 0};
    exp_c[8]  = '{0, 6, 2, 1}; exp_c[9]  = '{0, 0, 2, 1};
    exp_c[10] = '{0, 3, 2, 1}; exp_c[11] = '{2, 0, 4, 0}; exp_c[12] = '{2, 0, 4, 0};
    exp_c[13] = '{2, 0, 1, 0};
    exp_c[14] = '{0, 6, 2, 1}; exp_c[15] = '{0, 0, 2, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cmd_rdy", int'(cmd_rdy), 0);
    chk("rst dramra_rdy", int'(dramra_rdy), 0);
    chk("rst payload", int'({cmd_type, cmd_ofs, cmd_len, cmd_last, o_wh, dramra}), 0);
    @(posedge clk); #1 rst = 1'b1;

    for (int k = 0; k < 5; k++) begin
      run_req(k);
      if (k == 2 && cq.size() == 2) chk("r2 back-to-back", cq[1].cyc - cq[0].cyc, 1);
    end

    // All-zero request: accepted, nothing issued.
    cq.delete(); dq.delete();
    do_req(16'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    repeat (10) @(negedge clk);
    chk("zero ncmd", cq.size(), 0);
    chk("zero ndram", dq.size(), 0);

    // Line fetch held off: second line's command must wait for it.
    cq.delete(); dq.delete();
    dramra_ack = 1'b0;
    do_req(16'd4, 16'd8, 16'd0, 16'd0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall dramra_rdy", int'(dramra_rdy), 1);
    chk("stall dramra", int'(dramra), 0);
    chk("stall ncmd", cq.size(), 1);
    @(posedge clk); #1 req_rdy = 1'b1;
    @(negedge clk);
    chk("busy req_ack", int'(req_ack), 0);
    #1 req_rdy = 1'b0;
    @(posedge clk); #1 dramra_ack = 1'b1;
    wait_cmds(2);
    chk("stall ncmd end", cq.size(), 2);
    if (cq.size() == 2) begin
      chk("stall c0 ofs", cq[0].ofs, 4);
      chk("stall c0 last", cq[0].last, 1);
      chk("stall c1 ofs", cq[1].ofs, 0);
      chk("stall c1 len", cq[1].len, 4);
    end
    chk("stall ndram", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("stall dram0", dq[0], 0);
      chk("stall dram1", dq[1], 1);
    end

    // Asynchronous reset while the second command is pending.
    cq.delete(); dq.delete();
    cmd_ack = 1'b0;
    do_req(16'd0, 16'd8, 16'd0, 16'd0, 1'b1);
    for (int t = 0; t < 20 && !cmd_rdy; t++) @(negedge clk);
    @(posedge clk); #1 cmd_ack = 1'b1;
    @(posedge clk); #1 cmd_ack = 1'b0;
    @(negedge clk);
    chk("pre-rst cmd_rdy", int'(cmd_rdy), 1);
    chk("pre-rst ofs", int'(cmd_ofs), 4);
    #2 rst = 1'b0;
    #1;
    chk("async cmd_rdy", int'(cmd_rdy), 0);
    chk("async dramra_rdy", int'(dramra_rdy), 0);
    @(posedge clk); #1 rst = 1'b1; cmd_ack = 1'b1;
    run_req(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
